// File: rtl/piece_ctrl.sv
// piece_ctrl: falling-piece controller, initiator side of the board interface.
//
// It owns the active piece registers (x, y, piece_type, dir) and the
// next-piece generator. It applies user moves only when the board's
// enables allow them, and it runs the gravity timer. A landed piece is
// committed through the refresh/refresh_done handshake. After the commit
// the next piece spawns, and game over is detected.
//
// Optional feature macro: HARD_DROP_EN.
//   When it is defined, key_hard in FALL enters a HARD state. HARD drops
//   the piece one row per cycle until edrop goes low, then locks it.
//   When it is undefined, key_hard is accepted on the port but has no effect.
//
// Parameters:
//   DROP_TICKS  clk cycles per gravity step (min 2)
//   SPAWN_X     spawn column
//   LFSR_SEED   nonzero next-piece LFSR seed
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start                 pulse, begins a game from IDLE
//   key_left/right/rot/down/boom/hard   debounced one-cycle key pulses
//   el, er, eu, edrop     board enables for the current piece
//   overflow              current piece overlaps occupied cells
//   refresh_done          board finished commit/line clear (pulse)
//   x, y                  piece column/row origin
//   piece_type            piece type 1..7, 0 = none. This is the "type"
//                         signal; "type" is a reserved word in SystemVerilog.
//   dir                   rotation
//   next_type             preview piece 1..7
//   refresh               commit request pulse
//   boom                  bomb request pulse
//   game_over             sticky game-over flag
module piece_ctrl #(
  parameter int          DROP_TICKS = 50000000,
  parameter int          SPAWN_X    = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_rot,
  input  logic       key_down,
  input  logic       key_boom,
  input  logic       key_hard,
  input  logic       el,
  input  logic       er,
  input  logic       eu,
  input  logic       edrop,
  input  logic       overflow,
  input  logic       refresh_done,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic [2:0] piece_type,
  output logic [1:0] dir,
  output logic [2:0] next_type,
  output logic       refresh,
  output logic       boom,
  output logic       game_over
);

  localparam int TICK_W = (DROP_TICKS > 2) ? $clog2(DROP_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DROP_TICKS - 1);
  localparam logic [4:0] SPAWN_COL = 5'(SPAWN_X);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_CHECK,
    S_FALL,
    S_LOCK,
    S_WAIT_REF,
    S_OVER
`ifdef HARD_DROP_EN
    ,S_HARD
`endif
  } state_t;

  state_t            state;
  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic [TICK_W-1:0] tick;
  logic              tick_wrap;

`ifndef HARD_DROP_EN
  // key_hard has no function in this build. The name of this net tells the
  // linter that the port is intentionally unused.
  logic hard_key_unused;
  assign hard_key_unused = key_hard;
`endif

  // A raw LFSR value of 0 maps to piece type 1, so the preview is never "none".
  function automatic logic [2:0] map_type(input logic [2:0] v);
    return (v == 3'd0) ? 3'd1 : v;
  endfunction

  // Fibonacci LFSR with taps 16,14,13,11. It free-runs every cycle, so the
  // piece sequence depends on how long the player takes between pieces.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  assign tick_wrap = (tick == TICK_LAST);

  // Main controller. The piece registers stay untouched from LOCK until
  // refresh_done, so the board reads a stable piece while it commits.
  // In FALL, one action is taken per cycle, picked in priority order.
  // A key whose enable is low does not count as an action.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      x          <= SPAWN_COL;
      y          <= 5'd0;
      piece_type <= 3'd0;
      dir        <= 2'd0;
      next_type  <= map_type(LFSR_SEED[2:0]);
      refresh    <= 1'b0;
      boom       <= 1'b0;
      game_over  <= 1'b0;
      tick       <= '0;
    end else begin
      refresh <= 1'b0;
      boom    <= 1'b0;
      case (state)
        S_IDLE: begin
          piece_type <= 3'd0;
          if (start) state <= S_SPAWN;
        end

        S_SPAWN: begin
          piece_type <= next_type;
          next_type  <= map_type(lfsr[2:0]);
          x          <= SPAWN_COL;
          y          <= 5'd0;
          dir        <= 2'd0;
          tick       <= '0;
          state      <= S_CHECK;
        end

        // The board's overflow flag needs one cycle to settle on the new piece.
        S_CHECK: begin
          if (overflow) begin
            game_over <= 1'b1;
            state     <= S_OVER;
          end else begin
            state <= S_FALL;
          end
        end

        S_FALL: begin
          tick <= tick_wrap ? '0 : tick + TICK_W'(1);
          if (tick_wrap || key_down) begin
            if (key_down) tick <= '0;
            if (edrop) begin
              y <= y + 5'd1;
            end else begin
              refresh <= 1'b1;
              state   <= S_LOCK;
            end
          end
`ifdef HARD_DROP_EN
          else if (key_hard) begin
            state <= S_HARD;
          end
`endif
          else if (key_left && el) begin
            x <= x - 5'd1;
          end else if (key_right && er) begin
            x <= x + 5'd1;
          end else if (key_rot && eu) begin
            dir <= dir + 2'd1;
          end else if (key_boom) begin
            boom <= 1'b1;
          end
        end

`ifdef HARD_DROP_EN
        S_HARD: begin
          if (edrop) begin
            y <= y + 5'd1;
          end else begin
            refresh <= 1'b1;
            state   <= S_LOCK;
          end
        end
`endif

        // refresh was raised on entry, so it is high for exactly this cycle.
        S_LOCK: begin
          state <= S_WAIT_REF;
        end

        S_WAIT_REF: begin
          if (refresh_done) state <= S_SPAWN;
        end

        S_OVER: begin
          state <= S_OVER;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piece_ctrl.sv
// tb_piece_ctrl: self-checking bench for piece_ctrl, using DROP_TICKS=4.
//
// Every cycle goes through apply_stimulus. That task drives the DUT inputs,
// advances a behavioural model of the controller (including its own copy of
// the LFSR), and pushes the expected output snapshot onto a scoreboard queue.
// Each test task pops the snapshot after the clock edge and compares it with
// the DUT outputs. The tasks also add direct checks against constants taken
// from the intended behaviour.
module tb_piece_ctrl;

  localparam int          DT   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, key_left, key_right, key_rot, key_down, key_boom, key_hard;
  logic       el, er, eu, edrop, overflow, refresh_done;
  logic [4:0] x, y;
  logic [2:0] piece_type, next_type;
  logic [1:0] dir;
  logic       refresh, boom, game_over;

  piece_ctrl #(.DROP_TICKS(DT), .SPAWN_X(3), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start),
    .key_left(key_left), .key_right(key_right), .key_rot(key_rot),
    .key_down(key_down), .key_boom(key_boom), .key_hard(key_hard),
    .el(el), .er(er), .eu(eu), .edrop(edrop), .overflow(overflow),
    .refresh_done(refresh_done),
    .x(x), .y(y), .piece_type(piece_type), .dir(dir), .next_type(next_type),
    .refresh(refresh), .boom(boom), .game_over(game_over)
  );

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] t;
    logic [1:0] d;
    logic [2:0] nt;
    logic       r;
    logic       b;
    logic       g;
  } snap_t;

  typedef struct packed {
    logic rst, start, k_left, k_right, k_rot, k_down, k_boom, k_hard;
    logic el, er, eu, edrop, overflow, done;
  } stim_t;

  typedef enum {M_IDLE, M_SPAWN, M_CHECK, M_FALL, M_LOCK, M_WAIT, M_OVER} mstate_t;

  snap_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  mstate_t     m_state = M_IDLE;
  snap_t       m;
  logic [15:0] m_lfsr;
  int          m_tick;

  function automatic logic [2:0] map3(input logic [2:0] v);
    return (v == 3'd0) ? 3'd1 : v;
  endfunction

  function automatic stim_t base();
    stim_t s;
    s = '0;
    s.el = 1'b1; s.er = 1'b1; s.eu = 1'b1; s.edrop = 1'b1;
    return s;
  endfunction

  function automatic snap_t observe();
    snap_t o;
    o.x = x; o.y = y; o.t = piece_type; o.d = dir; o.nt = next_type;
    o.r = refresh; o.b = boom; o.g = game_over;
    return o;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("x=%0d y=%0d t=%0d d=%0d nt=%0d r=%0b b=%0b g=%0b",
                     s.x, s.y, s.t, s.d, s.nt, s.r, s.b, s.g);
  endfunction

  // Behavioural model: computes the output snapshot after the coming edge.
  task automatic model_step(input stim_t s);
    logic [15:0] l_next;
    logic        wrap;
    logic [2:0]  act;
    l_next = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    if (s.rst) begin
      m_state = M_IDLE;
      m.x = 5'd3; m.y = 5'd0; m.t = 3'd0; m.d = 2'd0;
      m.nt = map3(SEED[2:0]);
      m.r = 1'b0; m.b = 1'b0; m.g = 1'b0;
      m_lfsr = SEED;
      m_tick = 0;
      return;
    end
    m.r = 1'b0;
    m.b = 1'b0;
    case (m_state)
      M_IDLE:  if (s.start) m_state = M_SPAWN;
      M_SPAWN: begin
        m.t = m.nt; m.nt = map3(m_lfsr[2:0]);
        m.x = 5'd3; m.y = 5'd0; m.d = 2'd0; m_tick = 0;
        m_state = M_CHECK;
      end
      M_CHECK: begin
        if (s.overflow) begin m.g = 1'b1; m_state = M_OVER; end
        else m_state = M_FALL;
      end
      M_FALL: begin
        wrap = (m_tick == DT - 1);
        // act: 1 drop, 2 left, 3 right, 4 rotate, 5 boom, 0 none
        if (wrap || s.k_down)       act = 3'd1;
        else if (s.k_left && s.el)  act = 3'd2;
        else if (s.k_right && s.er) act = 3'd3;
        else if (s.k_rot && s.eu)   act = 3'd4;
        else if (s.k_boom)          act = 3'd5;
        else                        act = 3'd0;
        m_tick = (wrap || s.k_down) ? 0 : m_tick + 1;
        case (act)
          3'd1: if (s.edrop) m.y = m.y + 5'd1;
                else begin m.r = 1'b1; m_state = M_LOCK; end
          3'd2: m.x = m.x - 5'd1;
          3'd3: m.x = m.x + 5'd1;
          3'd4: m.d = m.d + 2'd1;
          3'd5: m.b = 1'b1;
          default: ;
        endcase
      end
      M_LOCK: m_state = M_WAIT;
      M_WAIT: if (s.done) m_state = M_SPAWN;
      default: ;
    endcase
    m_lfsr = l_next;
  endtask

  // Drives one cycle of stimulus and queues the expected outputs after the edge.
  task automatic apply_stimulus(input stim_t s);
    rst = s.rst; start = s.start;
    key_left = s.k_left; key_right = s.k_right; key_rot = s.k_rot;
    key_down = s.k_down; key_boom = s.k_boom; key_hard = s.k_hard;
    el = s.el; er = s.er; eu = s.eu; edrop = s.edrop;
    overflow = s.overflow; refresh_done = s.done;
    model_step(s);
    exp_q.push_back(m);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t s;
    snap_t got, want;
    s = base();
    s.rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(s);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL reset: got %s want %s", fmt(got), fmt(want));
      end
    end
    checks++;
    if (next_type !== 3'd1 || piece_type !== 3'd0 || x !== 5'd3 || y !== 5'd0 ||
        refresh !== 1'b0 || boom !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_const: got nt=%0d t=%0d x=%0d y=%0d r=%0b b=%0b g=%0b want nt=1 t=0 x=3 y=0 r=0 b=0 g=0",
               next_type, piece_type, x, y, refresh, boom, game_over);
    end
  endtask

  task automatic test_gravity();
    stim_t s;
    snap_t got, want;
    s = base();
    s.start = 1'b1;
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(s);
      s.start = 1'b0;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL gravity: got %s want %s", fmt(got), fmt(want));
      end
      if (i == 1) begin
        checks++;
        if (!(piece_type inside {[3'd1:3'd7]})) begin
          errors++; $display("[TB] FAIL spawn_type: got %0d want 1..7", piece_type);
        end
      end
    end
    checks++;
    if (y !== 5'd2 || x !== 5'd3 || dir !== 2'd0) begin
      errors++; $display("[TB] FAIL gravity_pos: got x=%0d y=%0d d=%0d want x=3 y=2 d=0", x, y, dir);
    end
  endtask

  task automatic test_move();
    stim_t s;
    snap_t got, want;
    stim_t tbl[6];
    logic [4:0] xs[6];
    xs = '{5'd2, 5'd2, 5'd3, 5'd3, 5'd2, 5'd3};
    tbl[0] = base(); tbl[0].k_left = 1'b1;
    tbl[1] = base(); tbl[1].k_left = 1'b1; tbl[1].el = 1'b0;
    tbl[2] = base(); tbl[2].k_right = 1'b1;
    tbl[3] = base(); tbl[3].k_hard = 1'b1; tbl[3].k_left = 1'b1;
    tbl[4] = base(); tbl[4].k_hard = 1'b1; tbl[4].k_left = 1'b1;
    tbl[5] = base(); tbl[5].k_right = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s = tbl[i];
      apply_stimulus(s);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL move[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
      checks++;
      if (x !== xs[i]) begin
        errors++; $display("[TB] FAIL move_x[%0d]: got %0d want %0d", i, x, xs[i]);
      end
    end
  endtask

  task automatic test_rotate();
    stim_t s;
    snap_t got, want;
    logic [1:0] ds[6];
    ds = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    for (int i = 0; i < 8 && m_tick != 0; i++) begin
      apply_stimulus(base());
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL rotate_align: got %s want %s", fmt(got), fmt(want));
      end
    end
    for (int i = 0; i < 6; i++) begin
      s = base();
      s.k_rot = (i != 3);
      s.eu    = (i != 5);
      apply_stimulus(s);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL rotate[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
      checks++;
      if (dir !== ds[i]) begin
        errors++; $display("[TB] FAIL rotate_dir[%0d]: got %0d want %0d", i, dir, ds[i]);
      end
    end
  endtask

  task automatic test_lock();
    stim_t s;
    snap_t got, want;
    logic [14:0] held;
    logic [2:0]  prev_nt;
    bit seen;
    int highs;
    seen = 1'b0;
    highs = 0;
    s = base();
    s.edrop = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      apply_stimulus(s);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL lock_wait: got %s want %s", fmt(got), fmt(want));
      end
      if (refresh === 1'b1) begin seen = 1'b1; highs++; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL lock_timeout: got refresh=0 want refresh=1 within 8 cycles");
    end
    held    = {m.x, m.y, m.t, m.d};
    prev_nt = m.nt;
    for (int i = 0; i < 5; i++) begin
      s.done = (i == 4);
      apply_stimulus(s);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL lock_hold: got %s want %s", fmt(got), fmt(want));
      end
      if (refresh === 1'b1) highs++;
      checks++;
      if ({x, y, piece_type, dir} !== held) begin
        errors++; $display("[TB] FAIL piece_stable[%0d]: got %h want %h", i, {x, y, piece_type, dir}, held);
      end
    end
    checks++;
    if (highs != 1) begin
      errors++; $display("[TB] FAIL refresh_width: got %0d cycles want 1", highs);
    end
    s = base();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(s);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL respawn: got %s want %s", fmt(got), fmt(want));
      end
    end
    checks++;
    if (piece_type !== prev_nt || y !== 5'd0 || x !== 5'd3 || dir !== 2'd0) begin
      errors++;
      $display("[TB] FAIL respawn_piece: got t=%0d x=%0d y=%0d d=%0d want t=%0d x=3 y=0 d=0",
               piece_type, x, y, dir, prev_nt);
    end
  endtask

  task automatic test_tick_and_key();
    stim_t s;
    snap_t got, want;
    logic [4:0] sx, sy;
    for (int i = 0; i < 8 && m_tick != DT - 1; i++) begin
      apply_stimulus(base());
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL tick_align: got %s want %s", fmt(got), fmt(want));
      end
    end
    sx = m.x;
    sy = m.y;
    s = base();
    s.k_left = 1'b1;
    apply_stimulus(s);
    got = observe(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("[TB] FAIL tick_vs_left: got %s want %s", fmt(got), fmt(want));
    end
    checks++;
    if (x !== sx || y !== sy + 5'd1) begin
      errors++; $display("[TB] FAIL tick_priority: got x=%0d y=%0d want x=%0d y=%0d", x, y, sx, sy + 5'd1);
    end
    for (int i = 0; i < 2; i++) begin
      s = base();
      s.k_boom = (i == 0);
      apply_stimulus(s);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL boom_seq[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
      checks++;
      if (boom !== (i == 0) || refresh !== 1'b0) begin
        errors++; $display("[TB] FAIL boom_pulse[%0d]: got boom=%0b refresh=%0b want boom=%0b refresh=0",
                           i, boom, refresh, (i == 0));
      end
    end
  endtask

  task automatic test_game_over();
    stim_t s;
    snap_t got, want;
    // Lock the current piece, deliver refresh_done, then respawn into an overflow.
    for (int i = 0; i < 7; i++) begin
      s = base();
      s.edrop    = 1'b0;
      s.k_down   = (i == 0);
      s.done     = (i == 4);
      s.overflow = (i >= 5);
      apply_stimulus(s);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL over_entry[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    checks++;
    if (game_over !== 1'b1) begin
      errors++; $display("[TB] FAIL game_over_set: got %0b want 1", game_over);
    end
    for (int i = 0; i < 6; i++) begin
      s = base();
      s.start = 1'b1; s.k_left = 1'b1; s.k_right = 1'b1; s.k_rot = 1'b1;
      s.k_down = 1'b1; s.k_boom = 1'b1; s.k_hard = 1'b1; s.done = 1'b1;
      s.edrop = i[0];
      apply_stimulus(s);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL over_frozen[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
      checks++;
      if (refresh !== 1'b0 || boom !== 1'b0 || game_over !== 1'b1) begin
        errors++; $display("[TB] FAIL over_flags[%0d]: got r=%0b b=%0b g=%0b want r=0 b=0 g=1",
                           i, refresh, boom, game_over);
      end
    end
    // rst leaves OVER; a stray refresh_done in IDLE must not start anything.
    for (int i = 0; i < 4; i++) begin
      s = base();
      s.rst  = (i == 0);
      s.done = (i == 1);
      apply_stimulus(s);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL over_reset[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    checks++;
    if (game_over !== 1'b0 || piece_type !== 3'd0) begin
      errors++; $display("[TB] FAIL idle_after_rst: got g=%0b t=%0d want g=0 t=0", game_over, piece_type);
    end
    // Start a new game, lock the piece and assert rst while waiting for refresh_done.
    for (int i = 0; i < 6; i++) begin
      s = base();
      s.start  = (i == 0);
      s.edrop  = 1'b0;
      s.k_down = (i == 3);
      s.rst    = (i == 5);
      apply_stimulus(s);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("[TB] FAIL mid_reset[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    checks++;
    if (piece_type !== 3'd0 || x !== 5'd3 || y !== 5'd0 || refresh !== 1'b0 || next_type !== 3'd1) begin
      errors++; $display("[TB] FAIL mid_reset_vals: got t=%0d x=%0d y=%0d r=%0b nt=%0d want t=0 x=3 y=0 r=0 nt=1",
                         piece_type, x, y, refresh, next_type);
    end
  endtask

  initial begin
    $display("[TB] piece_ctrl bench start");
    test_reset();
    test_gravity();
    test_move();
    test_rotate();
    test_lock();
    test_tick_and_key();
    test_game_over();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/piece_ctrl.md
Name: piece_ctrl

Overview:
Falling-piece controller that drives the board store. It is the initiator side of the board interface. It owns the active piece registers (x, y, type, dir) and the next-piece generator. It applies user moves only when the board's enables permit them, and runs the gravity timer. It commits a landed piece through the refresh/refresh_done handshake, then spawns the next piece and detects game over.

Parameters:
DROP_TICKS, 50000000, clk cycles per gravity step (min 2)
SPAWN_X, 3, spawn column
LFSR_SEED, 16'hACE1, nonzero next-piece LFSR seed

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
start  in  1  one-cycle pulse, begins a game from IDLE
key_left, key_right, key_rot, key_down, key_boom, key_hard  in  1 each  one-cycle debounced pulses
el, er, eu, edrop  in  1 each  board enables for left/right/rotate/drop of current piece (combinational on x,y,type,dir)
overflow  in  1  current piece overlaps occupied cells
refresh_done  in  1  board finished commit/line clear (one-cycle pulse)
x  out  5  piece column origin
y  out  5  piece row origin
type  out  3  piece type 1..7 (0 = none)
dir  out  2  rotation
next_type  out  3  preview piece 1..7
refresh  out  1  commit request pulse
boom  out  1  bomb request pulse
game_over  out  1  sticky game-over flag

Behaviour:
- Reset values: x=SPAWN_X, y=0, type=0, dir=0, refresh=0, boom=0, game_over=0, tick counter=0.
- Reset values: LFSR=LFSR_SEED, next_type=map(LFSR_SEED[2:0]), state IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle while not in reset.
- Type mapping: map(v) = v for v 1..7; map(0) = 1.
- States and transitions:
  - IDLE: type=0. On start, go to SPAWN.
  - SPAWN (1 cycle): type<=next_type, next_type<=map(LFSR[2:0]), x<=SPAWN_X, y<=0, dir<=0, tick<=0. Go to CHECK.
  - CHECK (1 cycle, board enables settled on new piece): if overflow, set game_over=1 and go to OVER. Otherwise go to FALL.
  - FALL: tick counts 0..DROP_TICKS-1 and wraps; the wrap cycle is a gravity tick.
    - At most one action per cycle. Priority: gravity tick > key_down > key_hard (when enabled) > key_left > key_right > key_rot > key_boom. Lower-priority pulses in the same cycle are dropped.
    - tick or key_down: if edrop, y<=y+1 (key_down also clears tick). Else go to LOCK.
    - key_left with el: x<=x-1. key_right with er: x<=x+1.
    - key_rot with eu: dir<=dir+1, mod 4 (3 wraps to 0).
    - A key whose enable is 0 is ignored; no state change.
    - key_boom: boom=1 for exactly one cycle; stay in FALL.
  - LOCK (1 cycle): refresh=1. Go to WAIT_REF.
  - WAIT_REF: refresh=0. x, y, type and dir are held stable from LOCK until refresh_done; the board latches them the cycle after refresh. All keys ignored. On refresh_done, go to SPAWN.
  - OVER: all keys and start ignored; outputs frozen. Exit only via rst.
- refresh and boom are never asserted in the same cycle, and never outside LOCK/FALL respectively.
- rst mid-handshake, in any state, returns to IDLE with reset values. A late refresh_done arriving in IDLE is ignored.

Optional Feature:
HARD_DROP_EN: when defined, key_hard in FALL enters HARD.
- In HARD: y<=y+1 every cycle while edrop; at the first cycle with edrop=0, go to LOCK. Keys are ignored in HARD.
- When not defined: the key_hard port exists but is ignored, and the HARD state is absent.

Test Plan:
Bench uses DROP_TICKS=4 and a board model.
1. rst, then start -> x=3, y=0, dir=0, type in 1..7 by the 3rd cycle. With edrop=1, y increments 0,1,2 once every 4 cycles.
2. key_left with el=1 at x=3 -> x=2 the next cycle. key_left with el=0 -> x stays 2. key_right with er=1 -> x=3.
3. Four key_rot pulses with eu=1 -> dir 1,2,3,0. key_rot with eu=0 -> dir unchanged.
4. edrop=0 at a gravity tick -> refresh high exactly 1 cycle; x/y/type/dir constant until refresh_done, delivered 5 cycles later. Then type equals the prior next_type, and y=0.
5. Gravity tick coincident with key_left (el=1, edrop=1) -> y+1, x unchanged. key_boom alone -> boom single-cycle pulse.
6. overflow=1 during CHECK after a respawn -> game_over=1, no further refresh/boom, keys and start ignored. rst clears game_over and returns to IDLE.
